vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_pkg.sv | 21 ++
 rtl/vm_coin_decode.sv | 23 ++
 rtl/vending_machine_param.sv | 141 ++++++++++++++
 tb/tb_vending_machine_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the parameterised vending machine.
// State encoding, coin codes and the credit unit value of each coin.
// Purely declarative: no logic and no latency of its own.
package vending_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  // Coin codes, used on both the coin input and the change output
  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_5     = 2'b01;
  localparam logic [1:0] COIN_10    = 2'b10;

  // Credit value of each coin, in 5-rs units
  localparam logic [1:0] COIN_5_UNITS  = 2'd1;
  localparam logic [1:0] COIN_10_UNITS = 2'd2;

endpackage

// File: rtl/vm_coin_decode.sv
// Coin code decoder: maps a 2-bit coin code to its unit value and an illegal flag.
// Latency: purely combinational, zero cycles.
// No backpressure; illegal codes decode to value 0 with o_illegal set.
module vm_coin_decode
  import vending_pkg::*;
(
  input  logic [1:0] i_coin,
  output logic [1:0] o_value,
  output logic       o_illegal
);

  // Decode the coin code; anything other than a 5 or 10 coin is illegal
  always_comb begin
    o_value   = 2'd0;
    o_illegal = 1'b0;
    case (i_coin)
      COIN_5:  o_value = COIN_5_UNITS;
      COIN_10: o_value = COIN_10_UNITS;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: collects 5/10 coins, vends at PRICE, refunds change coin by coin.
// Latency: every output is registered; an accepted coin shows in credit one cycle later.
// Coins offered while busy, illegal, cancelled or overflowing are returned via a one-cycle coin_reject.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 7,
  parameter int CREDIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                vend,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // One extra bit so credit + coin can never wrap before the overflow compare
  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] LP_PRICE   = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] LP_MAX     = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0] LP_UNITS_5  = SUM_W'(COIN_5_UNITS);
  localparam logic [SUM_W-1:0] LP_UNITS_10 = SUM_W'(COIN_10_UNITS);

  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_vend;
  logic                r_change_valid;
  logic [1:0]          r_change_coin;
  logic                r_coin_reject;
  logic                r_busy;

  logic [1:0]       w_value;
  logic             w_illegal;
  logic [SUM_W-1:0] w_credit_ext;
  logic [SUM_W-1:0] w_value_ext;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_chg_units;
  logic             w_state_busy;
  logic             w_reject;
  logic             w_accept;
  logic [1:0]       w_state_nxt;
  logic [SUM_W-1:0] w_credit_nxt;
  logic [1:0]       w_change_coin_nxt;

  vm_coin_decode u_decode (
    .i_coin    (coin),
    .o_value   (w_value),
    .o_illegal (w_illegal)
  );

  assign w_credit_ext = {1'b0, r_credit};
  assign w_value_ext  = {{(SUM_W-2){1'b0}}, w_value};
  assign w_sum        = w_credit_ext + w_value_ext;
  assign w_state_busy = (r_state == ST_VEND) || (r_state == ST_CHANGE);

  // Change is paid largest coin first
  assign w_chg_units  = (w_credit_ext >= LP_UNITS_10) ? LP_UNITS_10 : LP_UNITS_5;

  // A simultaneous cancel always bounces the coin, even in states where cancel itself is ignored
  assign w_reject = coin_valid && (w_illegal || w_state_busy || cancel || (w_sum > LP_MAX));
  assign w_accept = coin_valid && !w_reject;

  // Next state and next credit
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = w_credit_ext;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_credit_nxt = w_value_ext;
          w_state_nxt  = (w_value_ext >= LP_PRICE) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Credit in COLLECT is always non-zero, so a refund has at least one coin to pay
        if (cancel) begin
          w_state_nxt = ST_CHANGE;
        end else if (w_accept) begin
          w_credit_nxt = w_sum;
          w_state_nxt  = (w_sum >= LP_PRICE) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_VEND: begin
        w_credit_nxt = w_credit_ext - LP_PRICE;
        w_state_nxt  = (w_credit_ext == LP_PRICE) ? ST_IDLE : ST_CHANGE;
      end
      ST_CHANGE: begin
        w_credit_nxt = w_credit_ext - w_chg_units;
        w_state_nxt  = (w_credit_ext == w_chg_units) ? ST_IDLE : ST_CHANGE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  // The change coin shown in a CHANGE cycle is chosen from the credit held in that cycle
  always_comb begin
    w_change_coin_nxt = COIN_NONE;
    if (w_state_nxt == ST_CHANGE) begin
      w_change_coin_nxt = (w_credit_nxt >= LP_UNITS_10) ? COIN_10 : COIN_5;
    end
  end

  // State, credit and all outputs registered together; reset discards any held credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NONE;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt[CREDIT_W-1:0];
      r_vend         <= (w_state_nxt == ST_VEND);
      r_change_valid <= (w_state_nxt == ST_CHANGE);
      r_change_coin  <= w_change_coin_nxt;
      r_coin_reject  <= w_reject;
      r_busy         <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
    end
  end

  assign vend         = r_vend;
  assign change_valid = r_change_valid;
  assign change_coin  = r_change_coin;
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param in three price configurations.
// Inputs are driven shortly after the rising edge, outputs sampled 1 time unit after it.
// Each instance is held in reset while another one is being exercised.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       rst_c = 1'b1;

  logic       a_vend, a_cv, a_rj, a_busy;
  logic [1:0] a_cc;
  logic [3:0] a_cr;
  logic       b_vend, b_cv, b_rj, b_busy;
  logic [1:0] b_cc;
  logic [3:0] b_cr;
  logic       c_vend, c_cv, c_rj, c_busy;
  logic [1:0] c_cc;
  logic [3:0] c_cr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vending_machine_param #(.PRICE(3), .MAX_CREDIT(7), .CREDIT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .vend(a_vend), .change_valid(a_cv), .change_coin(a_cc), .coin_reject(a_rj),
    .credit(a_cr), .busy(a_busy)
  );

  vending_machine_param #(.PRICE(7), .MAX_CREDIT(7), .CREDIT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .vend(b_vend), .change_valid(b_cv), .change_coin(b_cc), .coin_reject(b_rj),
    .credit(b_cr), .busy(b_busy)
  );

  vending_machine_param #(.PRICE(1), .MAX_CREDIT(7), .CREDIT_W(4)) dut_c (
    .clk(clk), .rst(rst_c), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .vend(c_vend), .change_valid(c_cv), .change_coin(c_cc), .coin_reject(c_rj),
    .credit(c_cr), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic o_v, input logic o_cv, input logic [1:0] o_cc,
                         input logic o_rj, input logic [3:0] o_cr, input logic o_b,
                         input logic e_v, input logic e_cv, input logic [1:0] e_cc,
                         input logic e_rj, input logic [3:0] e_cr, input logic e_b);
    chk({tag, ".vend"},   8'(o_v),  8'(e_v));
    chk({tag, ".chg_v"},  8'(o_cv), 8'(e_cv));
    chk({tag, ".chg_c"},  8'(o_cc), 8'(e_cc));
    chk({tag, ".reject"}, 8'(o_rj), 8'(e_rj));
    chk({tag, ".credit"}, 8'(o_cr), 8'(e_cr));
    chk({tag, ".busy"},   8'(o_b),  8'(e_b));
  endtask

  // Present inputs for one rising edge, then return them to idle
  task automatic drive(input logic cv, input logic [1:0] c, input logic cn);
    coin_valid = cv;
    coin       = c;
    cancel     = cn;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin       = 2'b00;
    cancel     = 1'b0;
  endtask

  initial begin
    #12;
    chk_all("a_reset", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);
    rst_a = 1'b0;

    // 5 then 10: exact price, vend without change
    drive(1, 2'b01, 0);
    chk_all("a_exact_c1", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd1, 0);
    drive(1, 2'b10, 0);
    chk_all("a_exact_vend", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 1, 0, 2'b00, 0, 4'd3, 1);
    drive(0, 2'b00, 0);
    chk_all("a_exact_idle", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    // 10 then 10: vend, then one 5 coin of change
    drive(1, 2'b10, 0);
    chk_all("a_over_c1", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd2, 0);
    drive(1, 2'b10, 0);
    chk_all("a_over_vend", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 1, 0, 2'b00, 0, 4'd4, 1);
    drive(0, 2'b00, 0);
    chk_all("a_over_chg", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 1, 2'b01, 0, 4'd1, 1);
    drive(0, 2'b00, 0);
    chk_all("a_over_idle", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    // 5 then cancel: refund a single 5 coin, no vend
    drive(1, 2'b01, 0);
    drive(0, 2'b00, 1);
    chk_all("a_cancel_chg", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 1, 2'b01, 0, 4'd1, 1);
    drive(0, 2'b00, 0);
    chk_all("a_cancel_idle", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    // 10, then 10 together with cancel: coin bounced, 10 refunded
    drive(1, 2'b10, 0);
    drive(1, 2'b10, 1);
    chk_all("a_cxl_coin", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 1, 2'b10, 1, 4'd2, 1);
    drive(0, 2'b00, 0);
    chk_all("a_cxl_idle", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    // Illegal codes rejected from IDLE, credit untouched
    drive(1, 2'b11, 0);
    chk_all("a_ill11", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 1, 4'd0, 0);
    drive(1, 2'b00, 0);
    chk_all("a_ill00", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 1, 4'd0, 0);

    // Cancel in IDLE does nothing
    drive(0, 2'b00, 1);
    chk_all("a_idle_cxl", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    // Coins offered during VEND and CHANGE are bounced, change sequence unaffected
    drive(1, 2'b10, 0);
    drive(1, 2'b10, 0);
    chk_all("a_busy_vend", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 1, 0, 2'b00, 0, 4'd4, 1);
    drive(1, 2'b01, 0);
    chk_all("a_busy_rj1", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 1, 2'b01, 1, 4'd1, 1);
    drive(1, 2'b10, 0);
    chk_all("a_busy_rj2", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 1, 4'd0, 0);

    // Credit held indefinitely while no coin arrives
    drive(1, 2'b01, 0);
    for (int i = 0; i < 20; i++) drive(0, 2'b00, 0);
    chk_all("a_hold", a_vend, a_cv, a_cc, a_rj, a_cr, a_busy, 0, 0, 2'b00, 0, 4'd1, 0);
    rst_a = 1'b1;

    // PRICE 7: fill to 6, overflowing coin bounced, then exact fill vends
    #2;
    rst_b = 1'b0;
    drive(1, 2'b10, 0);
    drive(1, 2'b10, 0);
    drive(1, 2'b10, 0);
    chk_all("b_six", b_vend, b_cv, b_cc, b_rj, b_cr, b_busy, 0, 0, 2'b00, 0, 4'd6, 0);
    drive(1, 2'b10, 0);
    chk_all("b_ovf", b_vend, b_cv, b_cc, b_rj, b_cr, b_busy, 0, 0, 2'b00, 1, 4'd6, 0);
    drive(1, 2'b01, 0);
    chk_all("b_vend", b_vend, b_cv, b_cc, b_rj, b_cr, b_busy, 1, 0, 2'b00, 0, 4'd7, 1);
    drive(0, 2'b00, 0);
    chk_all("b_idle", b_vend, b_cv, b_cc, b_rj, b_cr, b_busy, 0, 0, 2'b00, 0, 4'd0, 0);
    rst_b = 1'b1;

    // PRICE 1: reset asserted mid-CHANGE clears everything without a clock edge
    #2;
    rst_c = 1'b0;
    drive(1, 2'b10, 0);
    chk_all("c_vend", c_vend, c_cv, c_cc, c_rj, c_cr, c_busy, 1, 0, 2'b00, 0, 4'd2, 1);
    drive(0, 2'b00, 0);
    chk_all("c_chg", c_vend, c_cv, c_cc, c_rj, c_cr, c_busy, 0, 1, 2'b01, 0, 4'd1, 1);
    #2;
    rst_c = 1'b1;
    #1;
    chk_all("c_async_rst", c_vend, c_cv, c_cc, c_rj, c_cr, c_busy, 0, 0, 2'b00, 0, 4'd0, 0);
    #1;
    rst_c = 1'b0;
    drive(1, 2'b01, 0);
    chk_all("c_after_rst", c_vend, c_cv, c_cc, c_rj, c_cr, c_busy, 1, 0, 2'b00, 0, 4'd1, 1);
    drive(0, 2'b00, 0);
    chk_all("c_after_idle", c_vend, c_cv, c_cc, c_rj, c_cr, c_busy, 0, 0, 2'b00, 0, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
